// File: rtl/uart_pkg.sv
// Shared UART types and constants: parity codes, TX state enum, character-length helpers.
// Imported by the transmit engine and, later, the parametrised receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int   MIN_CHAR_LEN = 5;
    localparam logic STOP_1       = 1'b0;
    localparam logic STOP_2       = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Out-of-range lengths fall back to the widest character the instance supports.
    function automatic logic [3:0] eff_char_len(input logic [3:0] len, input int max_len);
        if (int'(len) < MIN_CHAR_LEN || int'(len) > max_len) begin
            return 4'(max_len);
        end
        return len;
    endfunction

    function automatic logic parity_en(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, zero read latency; a write while full is accepted
// only if a pop happens in the same cycle, otherwise it is dropped and sets a sticky overflow.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    input  logic                     i_err_clr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_rd;
    logic             w_wr;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_rd_data  = r_mem[r_rd_ptr];

    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh overflow outranks a simultaneous clear.
            if (i_wr_en && o_full && !w_rd) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with runtime divisor/length/parity/stop config and integrated TX FIFO;
// first start bit one clock after pop. Optional clear-to-send gating via macro UART_TX_CTS_EN.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [3:0]                    char_len,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_bits,
    input  logic                          send,
    input  logic                          wr_uart,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          err_clr,
`ifdef UART_TX_CTS_EN
    input  logic                          cts_n,
`endif
    output logic                          tx_line,
    output logic                          tx_busy,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic                          tx_fifo_err,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count
);
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [3:0]        r_len;
    logic [3:0]        r_bit_idx;
    logic [1:0]        r_par;
    logic              r_stop2;
    logic              r_stop_idx;
    logic              r_par_bit;
    logic [DATA_W-1:0] r_shift;

    logic              w_pop;
    logic              w_can_start;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_fifo_dat;
    logic [DATA_W-1:0] w_masked;
    logic [3:0]        w_len;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_wr_en    (wr_uart),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_dat),
        .i_err_clr  (err_clr),
        .o_full     (tx_fifo_full),
        .o_empty    (tx_fifo_empty),
        .o_overflow (tx_fifo_err),
        .o_count    (tx_fifo_count)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] r_cts_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cts_sync <= 2'b11;
        end else begin
            r_cts_sync <= {r_cts_sync[0], cts_n};
        end
    end

    assign w_can_start = send && !tx_fifo_empty && !r_cts_sync[1];
`else
    assign w_can_start = send && !tx_fifo_empty;
`endif

    assign w_len     = eff_char_len(char_len, DATA_W);
    assign w_bit_end = (r_baud_cnt == r_div);
    assign tx_busy   = (r_state != IDLE);

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(w_len)) begin
                w_masked[i] = w_fifo_dat[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_start) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_idx == r_len - 4'd1)) begin
                    w_state_nxt = parity_en(r_par) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end && (r_stop_idx || (r_stop2 == STOP_1))) begin
                    if (w_can_start) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (r_state)
            START:   tx_line = 1'b0;
            DATA:    tx_line = r_shift[0];
            PARITY:  tx_line = r_par_bit;
            default: tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_len      <= 4'(DATA_W);
            r_bit_idx  <= '0;
            r_par      <= PAR_NONE;
            r_stop2    <= STOP_1;
            r_stop_idx <= 1'b0;
            r_par_bit  <= 1'b0;
            r_shift    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                // Whole frame config is frozen here so mid-frame input changes are ignored.
                r_div      <= divisor;
                r_len      <= w_len;
                r_par      <= parity_type;
                r_stop2    <= stop_bits;
                r_shift    <= w_masked;
                r_par_bit  <= (parity_type == PAR_ODD) ? ~^w_masked : ^w_masked;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
            end else if (r_state != IDLE) begin
                if (w_bit_end) begin
                    r_baud_cnt <= '0;
                    if (r_state == DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                    if (r_state == STOP) begin
                        r_stop_idx <= 1'b1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + 1'b1;
                end
            end
        end
    end

endmodule
